// File: rtl/mips_dcache_pkg.sv
// mips_dcache_pkg
//   Shared definitions for the MIPS data cache: FSM state encoding, word/line/address
//   widths and small helpers for slicing word addresses and lines.
//   No ports (package).
package mips_dcache_pkg;

    localparam int unsigned WORD_W         = 32;
    localparam int unsigned WORDS_PER_LINE = 4;
    localparam int unsigned LINE_W         = WORD_W * WORDS_PER_LINE;
    localparam int unsigned PADDR_W        = 30;  // core word address
    localparam int unsigned BLK_ADDR_W     = 28;  // memory block (line) address

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WB    = 2'd1,
        S_ALLOC = 2'd2
    } state_e;

    typedef logic [WORD_W-1:0]     word_t;
    typedef logic [LINE_W-1:0]     line_t;
    typedef logic [PADDR_W-1:0]    paddr_t;
    typedef logic [BLK_ADDR_W-1:0] blk_addr_t;

    function automatic logic [1:0] addr_off(input paddr_t a);
        return a[1:0];
    endfunction

    function automatic blk_addr_t addr_blk(input paddr_t a);
        return a[PADDR_W-1:2];
    endfunction

    // Word 0 lives in the least significant bits of a line.
    function automatic word_t line_word(input line_t l, input logic [1:0] off);
        return l[WORD_W*off +: WORD_W];
    endfunction

    function automatic line_t line_merge(input line_t l, input logic [1:0] off, input word_t w);
        line_t r;
        r = l;
        r[WORD_W*off +: WORD_W] = w;
        return r;
    endfunction

endpackage

// File: rtl/mips_dcache_if.sv
// mips_dcache_if
//   Bundles the core-side request port (proc_*) and the block-memory port (mem_*) of the
//   data cache.
//   slave  : the cache (takes core requests, issues memory requests)
//   master : the environment (core + block memory)
interface mips_dcache_if;
    import mips_dcache_pkg::*;

    logic      proc_read;
    logic      proc_write;
    paddr_t    proc_addr;
    word_t     proc_wdata;
    logic      proc_stall;
    word_t     proc_rdata;

    logic      mem_read;
    logic      mem_write;
    blk_addr_t mem_addr;
    line_t     mem_wdata;
    logic      mem_ready;
    line_t     mem_rdata;

    modport slave (
        input  proc_read, proc_write, proc_addr, proc_wdata, mem_ready, mem_rdata,
        output proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output proc_read, proc_write, proc_addr, proc_wdata, mem_ready, mem_rdata,
        input  proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mips_dcache_line_array.sv
// mips_dcache_line_array
//   Data/tag/valid/dirty storage for the direct-mapped cache.
//   Ports:
//     clk, rst            clock, sync active-high reset (clears valid/dirty only)
//     idx                 line index for both the read and the write port
//     rd_line/tag/valid/dirty  combinational read of line idx
//     wr_word, wr_off, wr_wdata  store one word into line idx and mark it dirty
//     wr_line, wr_ldata, wr_tag  refill line idx: valid=1, dirty=0
module mips_dcache_line_array
    import mips_dcache_pkg::*;
#(
    parameter int unsigned LINE_IDX_W = 3,
    parameter int unsigned TAG_W      = BLK_ADDR_W - LINE_IDX_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LINE_IDX_W-1:0] idx,
    output line_t                 rd_line,
    output logic [TAG_W-1:0]      rd_tag,
    output logic                  rd_valid,
    output logic                  rd_dirty,
    input  logic                  wr_word,
    input  logic [1:0]            wr_off,
    input  word_t                 wr_wdata,
    input  logic                  wr_line,
    input  line_t                 wr_ldata,
    input  logic [TAG_W-1:0]      wr_tag
);

    localparam int unsigned NUM_LINES = 2 ** LINE_IDX_W;

    line_t                 data_q [NUM_LINES];
    logic [TAG_W-1:0]      tag_q  [NUM_LINES];
    logic [NUM_LINES-1:0]  valid_q;
    logic [NUM_LINES-1:0]  dirty_q;

    assign rd_line  = data_q[idx];
    assign rd_tag   = tag_q[idx];
    assign rd_valid = valid_q[idx];
    assign rd_dirty = dirty_q[idx];

    // Data and tags are deliberately not reset; valid gates their use.
    always_ff @(posedge clk) begin
        if (wr_line) begin
            data_q[idx] <= wr_ldata;
            tag_q[idx]  <= wr_tag;
        end else if (wr_word) begin
            data_q[idx] <= line_merge(data_q[idx], wr_off, wr_wdata);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (wr_line) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end else if (wr_word) begin
            dirty_q[idx] <= 1'b1;
        end
    end

endmodule

// File: rtl/mips_dcache.sv
// mips_dcache
//   Direct-mapped, write-back, write-allocate data cache between the MIPS memory stage and
//   a 128-bit block memory. Hits complete combinationally; misses stall the core through
//   an optional write-back (S_WB) and a refill (S_ALLOC).
//   Ports:
//     clk, rst   clock, sync active-high reset
//     bus        mips_dcache_if.slave: proc_* core port, mem_* block-memory port
//     hit_cnt, miss_cnt  saturating request counters, present only when
//                        DCACHE_PERF_CNT_EN is defined
module mips_dcache
    import mips_dcache_pkg::*;
#(
    parameter int unsigned LINE_IDX_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    mips_dcache_if.slave       bus
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [31:0]        hit_cnt,
    output logic [31:0]        miss_cnt
`endif
);

    localparam int unsigned TAG_W = BLK_ADDR_W - LINE_IDX_W;

    state_e                state_q, state_d;
    logic                  mem_read_q, mem_read_d;
    logic                  mem_write_q, mem_write_d;
    blk_addr_t             mem_addr_q, mem_addr_d;
    line_t                 mem_wdata_q, mem_wdata_d;

    logic [LINE_IDX_W-1:0] idx;
    logic [TAG_W-1:0]      tag;
    line_t                 rd_line;
    logic [TAG_W-1:0]      rd_tag;
    logic                  rd_valid, rd_dirty;
    logic                  wr_word, wr_line;
    logic                  req, hit;

    assign idx = bus.proc_addr[LINE_IDX_W+1:2];
    assign tag = bus.proc_addr[PADDR_W-1:LINE_IDX_W+2];
    assign req = bus.proc_read | bus.proc_write;
    assign hit = rd_valid && (rd_tag == tag);

    mips_dcache_line_array #(
        .LINE_IDX_W (LINE_IDX_W),
        .TAG_W      (TAG_W)
    ) u_lines (
        .clk      (clk),
        .rst      (rst),
        .idx      (idx),
        .rd_line  (rd_line),
        .rd_tag   (rd_tag),
        .rd_valid (rd_valid),
        .rd_dirty (rd_dirty),
        .wr_word  (wr_word),
        .wr_off   (addr_off(bus.proc_addr)),
        .wr_wdata (bus.proc_wdata),
        .wr_line  (wr_line),
        .wr_ldata (bus.mem_rdata),
        .wr_tag   (tag)
    );

    always_comb begin
        state_d        = state_q;
        mem_read_d     = mem_read_q;
        mem_write_d    = mem_write_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        bus.proc_stall = 1'b0;
        wr_word        = 1'b0;
        wr_line        = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (hit) begin
                        // Read+write together is a write.
                        wr_word = bus.proc_write;
                    end else begin
                        bus.proc_stall = 1'b1;
                        if (rd_valid && rd_dirty) begin
                            state_d     = S_WB;
                            mem_write_d = 1'b1;
                            mem_addr_d  = {rd_tag, idx};
                            mem_wdata_d = rd_line;
                        end else begin
                            state_d    = S_ALLOC;
                            mem_read_d = 1'b1;
                            mem_addr_d = addr_blk(bus.proc_addr);
                        end
                    end
                end
            end
            S_WB: begin
                bus.proc_stall = 1'b1;
                if (bus.mem_ready) begin
                    state_d     = S_ALLOC;
                    mem_write_d = 1'b0;
                    mem_read_d  = 1'b1;
                    mem_addr_d  = addr_blk(bus.proc_addr);
                end
            end
            S_ALLOC: begin
                bus.proc_stall = 1'b1;
                if (bus.mem_ready) begin
                    state_d    = S_IDLE;
                    mem_read_d = 1'b0;
                    wr_line    = 1'b1;
                end
            end
            default: begin
                state_d     = S_IDLE;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign bus.proc_rdata = line_word(rd_line, addr_off(bus.proc_addr));
    assign bus.mem_read   = mem_read_q;
    assign bus.mem_write  = mem_write_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;

`ifdef DCACHE_PERF_CNT_EN
    logic        fill_done_q;
    logic [31:0] hit_q, miss_q;

    // The hit that completes a refilled miss belongs to that miss, so it is skipped.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_done_q <= 1'b0;
            hit_q       <= '0;
            miss_q      <= '0;
        end else begin
            fill_done_q <= (state_q == S_ALLOC) && bus.mem_ready;
            if (state_q == S_IDLE && req) begin
                if (hit) begin
                    if (!fill_done_q && hit_q != '1) hit_q <= hit_q + 32'd1;
                end else if (miss_q != '1) begin
                    miss_q <= miss_q + 32'd1;
                end
            end
        end
    end

    assign hit_cnt  = hit_q;
    assign miss_cnt = miss_q;
`endif

endmodule

// File: tb/tb_mips_dcache.sv
// tb_mips_dcache
//   Acts as core and block memory for mips_dcache. A reference model (flat word memory
//   plus per-index valid/dirty/tag bookkeeping) predicts hit/miss, write-back contents,
//   refill addresses and load data for directed and random requests.
module tb_mips_dcache;
    import mips_dcache_pkg::*;

    localparam int unsigned IDX_W = 3;
    localparam int unsigned NL    = 2 ** IDX_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mips_dcache_if bus ();
`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    mips_dcache #(
        .LINE_IDX_W (IDX_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave)
`ifdef DCACHE_PERF_CNT_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    int ncmp  = 0;
    int nfail = 0;

    // Reference model: gmem = architectural contents (latest stores), bmem = block memory.
    logic [31:0] gmem [int unsigned];
    logic [31:0] bmem [int unsigned];
    bit          m_valid [NL];
    bit          m_dirty [NL];
    int unsigned m_tag   [NL];
    int unsigned m_hits  = 0;
    int unsigned m_miss  = 0;

    function automatic logic [31:0] init_word(input int unsigned a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [31:0] bword(input int unsigned a);
        return bmem.exists(a) ? bmem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] gword(input int unsigned a);
        return gmem.exists(a) ? gmem[a] : bword(a);
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NL; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        gmem.delete();  // dirty data still in the cache is lost
        m_hits = 0;
        m_miss = 0;
    endtask

    task automatic chk_cnt();
`ifdef DCACHE_PERF_CNT_EN
        chk("hit_cnt", hit_cnt, m_hits);
        chk("miss_cnt", miss_cnt, m_miss);
`endif
    endtask

    task automatic idle_cycle();
        cyc();
        bus.proc_read  = 1'b0;
        bus.proc_write = 1'b0;
        bus.mem_ready  = 1'($urandom_range(0, 1));  // must be ignored in S_IDLE
        bus.mem_rdata  = {$urandom, $urandom, $urandom, $urandom};
        #1;
        chk("idle_stall", bus.proc_stall, 0);
        chk("idle_mem", {bus.mem_write, bus.mem_read}, 2'b00);
    endtask

    // One core request; lat < 0 picks a random memory latency.
    task automatic do_req(input bit rd, input bit wr, input logic [29:0] a,
                          input logic [31:0] wd, input int lat);
        int unsigned idx = (int'(a) >> 2) % NL;
        int unsigned tag = int'(a) >> (2 + IDX_W);
        int unsigned blk = int'(a) >> 2;
        int unsigned ob;
        bit          mhit;
        logic [127:0] line;
        int          l;
        cyc();
        bus.proc_read  = rd;
        bus.proc_write = wr;
        bus.proc_addr  = a;
        bus.proc_wdata = wd;
        bus.mem_ready  = 1'b0;
        #1;
        mhit = m_valid[idx] && (m_tag[idx] == tag);
        chk("req_stall", bus.proc_stall, !mhit);
        if (!mhit) begin
            m_miss++;
            if (m_valid[idx] && m_dirty[idx]) begin
                ob = (m_tag[idx] << IDX_W) | idx;
                for (int w = 0; w < 4; w++) line[w*32 +: 32] = gword(ob * 4 + w);
                cyc();
                #1;
                chk("wb_sig", {bus.proc_stall, bus.mem_write, bus.mem_read}, 3'b110);
                chk("wb_addr", bus.mem_addr, ob);
                chk("wb_wdata", bus.mem_wdata, line);
                l = (lat < 0) ? int'($urandom_range(0, 3)) : lat;
                repeat (l) begin
                    cyc();
                    #1;
                    chk("wb_hold", {bus.proc_stall, bus.mem_write, bus.mem_read}, 3'b110);
                end
                cyc();
                bus.mem_ready = 1'b1;
                for (int w = 0; w < 4; w++) bmem[ob * 4 + w] = line[w*32 +: 32];
                cyc();
                bus.mem_ready = 1'b0;
                #1;
            end else begin
                cyc();
                #1;
            end
            chk("alloc_sig", {bus.proc_stall, bus.mem_write, bus.mem_read}, 3'b101);
            chk("alloc_addr", bus.mem_addr, blk);
            l = (lat < 0) ? int'($urandom_range(0, 3)) : lat;
            repeat (l) begin
                cyc();
                #1;
                chk("alloc_hold", {bus.proc_stall, bus.mem_write, bus.mem_read}, 3'b101);
            end
            cyc();
            bus.mem_ready = 1'b1;
            for (int w = 0; w < 4; w++) bus.mem_rdata[w*32 +: 32] = bword((blk & ~32'd3) * 0 + blk * 4 + w);
            cyc();
            bus.mem_ready = 1'b0;
            bus.mem_rdata = {$urandom, $urandom, $urandom, $urandom};
            #1;
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_tag[idx]   = tag;
            chk("fill_stall", bus.proc_stall, 0);
            chk("fill_mem_idle", {bus.mem_write, bus.mem_read}, 2'b00);
        end else begin
            m_hits++;
        end
        if (rd) chk("rdata", bus.proc_rdata, gword(int'(a)));
        if (wr) begin
            gmem[int'(a)] = wd;
            m_dirty[idx]  = 1'b1;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [29:0] a;
        int unsigned op;
        int unsigned tsel;
        bit          r, w;

        rst            = 1'b1;
        bus.proc_read  = 1'b0;
        bus.proc_write = 1'b0;
        bus.proc_addr  = '0;
        bus.proc_wdata = '0;
        bus.mem_ready  = 1'b0;
        bus.mem_rdata  = '0;
        model_reset();
        cyc();
        cyc();
        #1;
        chk("rst_stall", bus.proc_stall, 0);
        chk("rst_mem_rw", {bus.mem_write, bus.mem_read}, 2'b00);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk_cnt();
        cyc();
        rst = 1'b0;

        // Cold read of a known line {D,C,B,A}
        bmem[32'h10] = 32'hAAAA_0000;
        bmem[32'h11] = 32'hBBBB_1111;
        bmem[32'h12] = 32'hCCCC_2222;
        bmem[32'h13] = 32'hDDDD_3333;
        do_req(1'b1, 1'b0, 30'h10, 32'h0, 3);
        chk("cold_rdata_a", bus.proc_rdata, 32'hAAAA_0000);
        // Write hit then read back
        do_req(1'b0, 1'b1, 30'h11, 32'hDEAD_BEEF, -1);
        do_req(1'b1, 1'b0, 30'h11, 32'h0, -1);
        chk("wr_rd_back", bus.proc_rdata, 32'hDEAD_BEEF);
        // Dirty eviction to block 0x4, refill of block 0xC
        do_req(1'b1, 1'b0, 30'h31, 32'h0, 2);
        chk("evict_wb_word1", bmem[32'h11], 32'hDEAD_BEEF);
        // Clean eviction, same index
        do_req(1'b1, 1'b0, 30'h51, 32'h0, 1);
        // Long memory latency, then a different request
        do_req(1'b1, 1'b1, 30'h2A6, 32'h1234_5678, 20);
        do_req(1'b1, 1'b0, 30'h51, 32'h0, -1);
        idle_cycle();
        chk_cnt();

        // Reset while a write-back is outstanding
        do_req(1'b0, 1'b1, 30'h11, 32'hCAFE_F00D, -1);
        cyc();
        bus.proc_read  = 1'b1;
        bus.proc_write = 1'b0;
        bus.proc_addr  = 30'h71;
        #1;
        chk("pre_rst_stall", bus.proc_stall, 1);
        cyc();
        #1;
        chk("pre_rst_wb", bus.mem_write, 1);
        cyc();
        rst           = 1'b1;
        bus.proc_read = 1'b0;
        cyc();
        rst = 1'b0;
        #1;
        model_reset();
        chk("post_rst_sig", {bus.proc_stall, bus.mem_write, bus.mem_read}, 3'b000);
        chk_cnt();
        do_req(1'b1, 1'b0, 30'h11, 32'h0, 2);

        // Random traffic over a few tags so hits, clean and dirty evictions all occur
        for (int i = 0; i < 400; i++) begin
            op = $urandom_range(0, 9);
            if (op < 2) begin
                idle_cycle();
            end else begin
                tsel = $urandom_range(0, 4);
                a = {(tsel == 4) ? 25'h1FF_FFFF : 25'(tsel),
                     3'($urandom_range(0, NL - 1)), 2'($urandom_range(0, 3))};
                r = (op < 6) || (op == 9);
                w = (op >= 6);
                do_req(r, w, a, $urandom, -1);
            end
        end
        idle_cycle();
        chk_cnt();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
